lfsr_stream_cipher: RTL

- Parametrised LFSR stream encryptor/decryptor; successor to the fixed 6-bit, fixed-schedule Lab 4 encrypt top level.
- Reads configuration words (pre_len, taps, seed) from data memory, then streams a message through an XOR with a W-bit Fibonacci LFSR.
- Encrypt mode prepends a 0x5F preamble. Decrypt mode strips the preamble.
- Sits between the controller and dat_mem. Handshake is a start pulse plus busy/done; done is completion-accurate, not at a fixed count.

---
 rtl/lfsr_stream_cipher.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/lfsr_stream_cipher.sv
// lfsr_stream_cipher
// Loads pre_len / taps / seed from data memory, then streams MSG_LEN words
// through an XOR with a Fibonacci LFSR keystream. Encrypt prepends a PAD
// preamble; decrypt skips over it without writing.
// Build option: define LFSR_PARITY_EN (DW = 8) to carry a 7-bit payload with
// even parity in the top bit; decrypt then reports odd-parity reads on
// parity_err. Without it, parity_err stays 0 and all DW bits are XORed.
module lfsr_stream_cipher #(
    parameter int            DW       = 8,
    parameter int            AW       = 8,
    parameter int            LW       = 6,
    parameter int            MSG_LEN  = 61,
    parameter int            MAX_PRE  = 15,
    parameter int            CFG_BASE = 61,
    parameter int            SRC_BASE = 0,
    parameter int            DST_BASE = 64,
    parameter logic [DW-1:0] PAD      = DW'(8'h5F)
) (
    input  logic          clk,
    input  logic          init_n,
    input  logic          start,
    input  logic          mode,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] mem_raddr,
    input  logic [DW-1:0] mem_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_waddr,
    output logic [DW-1:0] mem_wdata,
    output logic          parity_err
);

    localparam int PW = $clog2(MAX_PRE + 1);
    localparam int IW = $clog2(MAX_PRE + MSG_LEN + 1);

    typedef enum logic [2:0] {
        IDLE, LD_PRE, LD_TAPS, LD_SEED, SEED, STREAM, DONE
    } state_t;

    state_t        state;
    logic          mode_q;
    logic [PW-1:0] pre_len;
    logic [LW-1:0] taps;
    logic [LW-1:0] seed;
    logic [LW-1:0] lfsr;
    logic [IW-1:0] idx;

    logic [DW-1:0] key;
    logic [AW-1:0] idx_a;
    logic [AW-1:0] pre_a;
    logic          in_pre;
    logic          last_idx;
    logic          par_fail;

    // Saturate the preamble length read from memory.
    function automatic logic [PW-1:0] clamp_pre(input logic [DW-1:0] raw);
        if (raw > DW'(MAX_PRE)) return PW'(MAX_PRE);
        return raw[PW-1:0];
    endfunction

    // An all-zero LFSR never leaves zero, so substitute 1.
    function automatic logic [LW-1:0] fix_seed(input logic [LW-1:0] raw);
        return (raw == '0) ? LW'(1) : raw;
    endfunction

    // Shape an encrypted word before it is written.
    function automatic logic [DW-1:0] enc_out(input logic [DW-1:0] x);
`ifdef LFSR_PARITY_EN
        return {^x[DW-2:0], x[DW-2:0]};
`else
        return x;
`endif
    endfunction

    // Shape a decrypted word before it is written.
    function automatic logic [DW-1:0] dec_out(input logic [DW-1:0] x);
`ifdef LFSR_PARITY_EN
        return {1'b0, x[DW-2:0]};
`else
        return x;
`endif
    endfunction

    assign key      = DW'(lfsr);
    assign idx_a    = AW'(idx);
    assign pre_a    = AW'(pre_len);
    assign in_pre   = (idx < IW'(pre_len));
    assign last_idx = (idx == IW'(pre_len) + IW'(MSG_LEN - 1));

    // Control FSM: config load, keystream advance, busy/done/parity flags.
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state      <= IDLE;
            mode_q     <= 1'b0;
            pre_len    <= '0;
            taps       <= '0;
            seed       <= '0;
            lfsr       <= '0;
            idx        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mode_q     <= mode;
                        busy       <= 1'b1;
                        parity_err <= 1'b0;
                        state      <= LD_PRE;
                    end
                end
                LD_PRE: begin
                    pre_len <= clamp_pre(mem_rdata);
                    state   <= LD_TAPS;
                end
                LD_TAPS: begin
                    taps  <= mem_rdata[LW-1:0];
                    state <= LD_SEED;
                end
                LD_SEED: begin
                    seed  <= fix_seed(mem_rdata[LW-1:0]);
                    state <= SEED;
                end
                SEED: begin
                    lfsr  <= seed;
                    idx   <= '0;
                    state <= STREAM;
                end
                STREAM: begin
                    lfsr <= {lfsr[LW-2:0], ^(lfsr & taps)};
                    idx  <= idx + IW'(1);
                    if (par_fail) parity_err <= 1'b1;
                    if (last_idx) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Memory addressing and XOR datapath, driven from the current state.
    always_comb begin
        mem_raddr = '0;
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        par_fail  = 1'b0;
        case (state)
            LD_PRE:  mem_raddr = AW'(CFG_BASE);
            LD_TAPS: mem_raddr = AW'(CFG_BASE + 1);
            LD_SEED: mem_raddr = AW'(CFG_BASE + 2);
            STREAM: begin
                if (!mode_q) begin
                    mem_we    = 1'b1;
                    mem_waddr = AW'(DST_BASE) + idx_a;
                    if (in_pre) begin
                        mem_wdata = enc_out(PAD ^ key);
                    end else begin
                        mem_raddr = AW'(SRC_BASE) + idx_a - pre_a;
                        mem_wdata = enc_out(mem_rdata ^ key);
                    end
                end else begin
                    mem_raddr = AW'(SRC_BASE) + idx_a;
                    if (!in_pre) begin
                        mem_we    = 1'b1;
                        mem_waddr = AW'(DST_BASE) + idx_a - pre_a;
                        mem_wdata = dec_out(mem_rdata ^ key);
`ifdef LFSR_PARITY_EN
                        par_fail  = ^mem_rdata;
`endif
                    end
                end
            end
            default: ;
        endcase
    end

endmodule
